// File: rtl/pbit_sched_pkg.sv
// Shared types, default sizes and index-to-one-hot helper for the p-bit
// update scheduler.
package pbit_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    localparam int N_GROUPS_DEF = 3;
    localparam int GROUP_W_DEF  = 3;
    localparam int DWELL_W_DEF  = 8;
    localparam int SWEEP_W_DEF  = 16;

    // Out-of-range indices produce an all-zero mask rather than aliasing.
    function automatic logic [31:0] group_to_onehot(input logic [31:0] idx,
                                                    input int unsigned n);
        logic [31:0] mask;
        mask = '0;
        if (idx < n) begin
            mask = 32'd1 << idx;
        end
        return mask;
    endfunction

endpackage

// File: rtl/pbit_update_scheduler_group_onehot_decoder.sv
// Combinational group index to one-hot enable decoder, forced to zero when
// the scheduler is not running.
module group_onehot_decoder
    import pbit_sched_pkg::*;
#(
    parameter int N_GROUPS = N_GROUPS_DEF,
    parameter int GROUP_W  = GROUP_W_DEF
) (
    input  logic [GROUP_W-1:0]  idx,
    input  logic                en,
    output logic [N_GROUPS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = N_GROUPS'(group_to_onehot(32'(idx), N_GROUPS));
        end
    end

endmodule

// File: rtl/pbit_update_scheduler.sv
// Sequences grouped p-bit updates: walks the group index with a programmable
// dwell per group, counts sweeps, and stops after a programmed count or free-runs.
module pbit_update_scheduler
    import pbit_sched_pkg::*;
#(
    parameter int N_GROUPS = N_GROUPS_DEF,
    parameter int GROUP_W  = GROUP_W_DEF,
    parameter int DWELL_W  = DWELL_W_DEF,
    parameter int SWEEP_W  = SWEEP_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [DWELL_W-1:0]  dwell_cycles,
    input  logic [SWEEP_W-1:0]  num_sweeps,
    output logic [GROUP_W-1:0]  group_EN,
    output logic [N_GROUPS-1:0] Pbit_EN,
    output logic                group_strobe,
    output logic                sweep_done,
    output logic [SWEEP_W-1:0]  sweep_count,
    output logic                busy,
    output logic                done
);

    localparam logic [GROUP_W-1:0] GROUP_LAST = GROUP_W'(N_GROUPS - 1);

    sched_state_e        state_q, state_d;
    logic [GROUP_W-1:0]  group_q, group_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [DWELL_W-1:0]  dwell_lat_q, dwell_lat_d;
    logic [SWEEP_W-1:0]  num_sweeps_q, num_sweeps_d;
    logic [SWEEP_W-1:0]  sweep_count_q, sweep_count_d;
    logic [N_GROUPS-1:0] pbit_en_q, pbit_en_d;
    logic                group_strobe_q, group_strobe_d;
    logic                sweep_done_q, sweep_done_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dwell_end;
    logic                sweep_end;

    // A programmed dwell of 0 behaves like 1, so the terminal count is max(d,1)-1.
    function automatic logic [DWELL_W-1:0] last_dwell(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    always_comb begin
        state_d       = state_q;
        group_d       = group_q;
        dwell_cnt_d   = dwell_cnt_q;
        dwell_lat_d   = dwell_lat_q;
        num_sweeps_d  = num_sweeps_q;
        sweep_count_d = sweep_count_q;
        dwell_end     = (dwell_cnt_q == last_dwell(dwell_lat_q));
        sweep_end     = dwell_end && (group_q == GROUP_LAST);

        unique case (state_q)
            IDLE, DONE: begin
                if (start && !stop) begin
                    state_d       = RUN;
                    dwell_lat_d   = dwell_cycles;
                    num_sweeps_d  = num_sweeps;
                    sweep_count_d = '0;
                    group_d       = '0;
                    dwell_cnt_d   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d     = IDLE;
                    group_d     = '0;
                    dwell_cnt_d = '0;
                end else if (sweep_end) begin
                    dwell_cnt_d   = '0;
                    group_d       = '0;
                    sweep_count_d = sweep_count_q + SWEEP_W'(1);
                    if (num_sweeps_q != '0 && sweep_count_d == num_sweeps_q) begin
                        state_d = DONE;
                    end
                end else if (dwell_end) begin
                    dwell_cnt_d = '0;
                    group_d     = group_q + GROUP_W'(1);
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                group_d     = '0;
                dwell_cnt_d = '0;
            end
        endcase

        // Registered outputs are derived from the next state so they line up
        // with the cycle they describe.
        busy_d         = (state_d == RUN);
        done_d         = (state_d == DONE);
        group_strobe_d = busy_d && (dwell_cnt_d == '0);
        sweep_done_d   = busy_d && (group_d == GROUP_LAST)
                         && (dwell_cnt_d == last_dwell(dwell_lat_d));
    end

    group_onehot_decoder #(
        .N_GROUPS (N_GROUPS),
        .GROUP_W  (GROUP_W)
    ) u_decoder (
        .idx    (group_d),
        .en     (busy_d),
        .onehot (pbit_en_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            group_q        <= '0;
            dwell_cnt_q    <= '0;
            dwell_lat_q    <= '0;
            num_sweeps_q   <= '0;
            sweep_count_q  <= '0;
            pbit_en_q      <= '0;
            group_strobe_q <= 1'b0;
            sweep_done_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            group_q        <= group_d;
            dwell_cnt_q    <= dwell_cnt_d;
            dwell_lat_q    <= dwell_lat_d;
            num_sweeps_q   <= num_sweeps_d;
            sweep_count_q  <= sweep_count_d;
            pbit_en_q      <= pbit_en_d;
            group_strobe_q <= group_strobe_d;
            sweep_done_q   <= sweep_done_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign group_EN     = group_q;
    assign Pbit_EN      = pbit_en_q;
    assign group_strobe = group_strobe_q;
    assign sweep_done   = sweep_done_q;
    assign sweep_count  = sweep_count_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_pbit_update_scheduler.sv
// Scoreboard bench for pbit_update_scheduler: the reference model tracks elapsed
// run time and derives every output from it arithmetically.
module tb_pbit_update_scheduler;

    localparam int NG = 3;
    localparam int GW = 3;
    localparam int DW = 8;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [DW-1:0] dwell_cycles = '0;
    logic [SW-1:0] num_sweeps = '0;
    logic [GW-1:0] group_EN;
    logic [NG-1:0] Pbit_EN;
    logic          group_strobe;
    logic          sweep_done;
    logic [SW-1:0] sweep_count;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    pbit_update_scheduler #(
        .N_GROUPS (NG),
        .GROUP_W  (GW),
        .DWELL_W  (DW),
        .SWEEP_W  (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .dwell_cycles (dwell_cycles),
        .num_sweeps   (num_sweeps),
        .group_EN     (group_EN),
        .Pbit_EN      (Pbit_EN),
        .group_strobe (group_strobe),
        .sweep_done   (sweep_done),
        .sweep_count  (sweep_count),
        .busy         (busy),
        .done         (done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [25:0] exp_q[$];

    // Model: 0 idle, 1 running, 2 done. m_t = cycles elapsed since the run began.
    int m_state = 0;
    int m_t     = 0;
    int m_D     = 1;
    int m_N     = 0;
    int m_hold  = 0;

    function automatic logic [25:0] model_out();
        int g;
        logic [NG-1:0] pb;
        logic strobe, sd;
        logic [SW-1:0] cnt;
        if (m_state == 1) begin
            g      = (m_t / m_D) % NG;
            pb     = NG'(1 << g);
            strobe = ((m_t % m_D) == 0);
            sd     = ((m_t % (NG * m_D)) == (NG * m_D - 1));
            cnt    = SW'(m_t / (NG * m_D));
            return {GW'(g), pb, strobe, sd, cnt, 1'b1, 1'b0};
        end
        return {GW'(0), NG'(0), 1'b0, 1'b0, SW'(m_hold), 1'b0, (m_state == 2)};
    endfunction

    task automatic step(input logic s, input logic p, input int d, input int n);
        start        = s;
        stop         = p;
        dwell_cycles = DW'(d);
        num_sweeps   = SW'(n);
        if (rst) begin
            m_state = 0;
            m_hold  = 0;
        end else if (m_state == 1) begin
            if (p) begin
                m_hold  = m_t / (NG * m_D);
                m_state = 0;
            end else begin
                m_t++;
                if (m_N != 0 && m_t == NG * m_D * m_N) begin
                    m_state = 2;
                    m_hold  = m_N;
                end
            end
        end else if (s && !p) begin
            m_state = 1;
            m_t     = 0;
            m_D     = (d == 0) ? 1 : d;
            m_N     = n;
        end
        exp_q.push_back(model_out());
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Monitor: every clock the DUT presents one registered output snapshot.
    initial begin
        logic [25:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {group_EN, Pbit_EN, group_strobe, sweep_done, sweep_count, busy, done};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got grp=%0d en=%b stb=%b sd=%b cnt=%0d busy=%b done=%b, want grp=%0d en=%b stb=%b sd=%b cnt=%0d busy=%b done=%b",
                             $time, a[25:23], a[22:20], a[19], a[18], a[17:2], a[1], a[0],
                             e[25:23], e[22:20], e[19], e[18], e[17:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got no summary, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [25:0] snap;
        @(negedge clk);
        repeat (2) step(0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0);

        // dwell 2, one sweep
        step(1, 0, 2, 1);
        repeat (7) step(0, 0, 0, 0);

        // dwell 0 treated as 1, two sweeps
        step(1, 0, 0, 2);
        repeat (7) step(0, 0, 0, 0);

        // free-run then stop after 10 enabled cycles
        step(1, 0, 1, 0);
        repeat (9) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // start together with stop in IDLE
        step(1, 1, 2, 1);
        step(0, 0, 0, 0);

        // stop on the final sweep_done cycle
        step(1, 0, 1, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // start while running is ignored
        step(1, 0, 2, 1);
        step(0, 0, 0, 0);
        step(1, 0, 4, 0);
        step(1, 0, 1, 3);
        repeat (4) step(0, 0, 0, 0);

        // restart from DONE
        step(1, 0, 3, 1);
        repeat (10) step(0, 0, 0, 0);

        // asynchronous reset in the middle of group 1
        step(1, 0, 3, 0);
        repeat (4) step(0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        snap = {group_EN, Pbit_EN, group_strobe, sweep_done, sweep_count, busy, done};
        n_tests++;
        if (snap !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got outputs=%h, want 0 before any clock edge", snap);
        end
        @(negedge clk);
        step(0, 0, 0, 0);
        rst = 1'b0;
        step(1, 0, 2, 1);
        repeat (8) step(0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
